// File: rtl/sys_ctrl_gen.sv
// Command controller: decodes UART command frames into register-file and ALU
// transactions and streams read/ALU results into the TX FIFO, LS byte first.
module sys_ctrl_gen #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUN_WIDTH      = 4,
   parameter int RES_BYTES      = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter logic [DATA_WIDTH-1:0] CMD_RF_WR   = 'hAA,
   parameter logic [DATA_WIDTH-1:0] CMD_RF_RD   = 'hBB,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 'hCC,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 'hDD
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [DATA_WIDTH-1:0]           RX_P_DATA,
   input  logic                            RX_D_VLD,
   output logic [ADDR_WIDTH-1:0]           RF_ADDR,
   output logic [DATA_WIDTH-1:0]           RF_WR_DATA,
   output logic                            RF_WR_EN,
   output logic                            RF_RD_EN,
   input  logic [DATA_WIDTH-1:0]           RF_RD_DATA,
   input  logic                            RF_RD_DATA_VLD,
   output logic [FUN_WIDTH-1:0]            ALU_FUN,
   output logic                            ALU_EN,
   output logic                            ALU_CLK_EN,
   input  logic [RES_BYTES*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                            ALU_OUT_VLD,
   output logic [DATA_WIDTH-1:0]           FIFO_WR_DATA,
   output logic                            FIFO_WR_INC,
   input  logic                            FIFO_FULL,
   output logic                            ERR_FLAG,
   output logic                            BUSY
);

   localparam int RES_W = RES_BYTES * DATA_WIDTH;
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int CNT_W = $clog2(RES_BYTES + 1);
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [3:0] {
      S_IDLE, S_RFW_ADDR, S_RFW_DATA, S_RFR_ADDR, S_RFR_WAIT,
      S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_PUSH
   } state_t;

   state_t              state_q, state_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [RES_W-1:0]    tx_buf_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ADDR_WIDTH-1:0] rf_addr_q;
   logic [DATA_WIDTH-1:0] rf_wr_data_q, fifo_wr_data_q;
   logic [FUN_WIDTH-1:0]  alu_fun_q;
   logic                rf_wr_en_q, rf_rd_en_q, alu_en_q, alu_clk_en_q;
   logic                fifo_wr_inc_q, err_q, busy_q;
   logic                err_d, evt;

   // evt marks an accepted byte or completion; it restarts the frame timeout.
   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      err_d   = 1'b0;
      evt     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == CMD_RF_WR)        state_d = S_RFW_ADDR;
               else if (RX_P_DATA == CMD_RF_RD)   state_d = S_RFR_ADDR;
               else if (RX_P_DATA == CMD_ALU_OP)  state_d = S_ALU_A;
               else if (RX_P_DATA == CMD_ALU_NOP) state_d = S_ALU_FUN;
               else                               err_d   = 1'b1;
            end
         end
         S_RFW_ADDR: if (RX_D_VLD) begin evt = 1'b1; state_d = S_RFW_DATA; end
         S_RFW_DATA: if (RX_D_VLD) begin evt = 1'b1; state_d = S_IDLE;     end
         S_RFR_ADDR: if (RX_D_VLD) begin evt = 1'b1; state_d = S_RFR_WAIT; end
         S_ALU_A:    if (RX_D_VLD) begin evt = 1'b1; state_d = S_ALU_B;    end
         S_ALU_B:    if (RX_D_VLD) begin evt = 1'b1; state_d = S_ALU_FUN;  end
         S_ALU_FUN:  if (RX_D_VLD) begin evt = 1'b1; state_d = S_ALU_WAIT; end
         S_RFR_WAIT: begin
            err_d = RX_D_VLD;
            if (RF_RD_DATA_VLD) begin evt = 1'b1; state_d = S_TX_PUSH; end
         end
         S_ALU_WAIT: begin
            err_d = RX_D_VLD;
            if (ALU_OUT_VLD) begin evt = 1'b1; state_d = S_TX_PUSH; end
         end
         S_TX_PUSH: begin
            err_d = RX_D_VLD;
            if (!FIFO_FULL && cnt_q <= CNT_W'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (TMO_EN && state_q != S_IDLE && state_q != S_TX_PUSH && !evt) begin
         if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= S_IDLE;
         tmo_q          <= '0;
         tx_buf_q       <= '0;
         cnt_q          <= '0;
         rf_addr_q      <= '0;
         rf_wr_data_q   <= '0;
         fifo_wr_data_q <= '0;
         alu_fun_q      <= '0;
         rf_wr_en_q     <= 1'b0;
         rf_rd_en_q     <= 1'b0;
         alu_en_q       <= 1'b0;
         alu_clk_en_q   <= 1'b0;
         fifo_wr_inc_q  <= 1'b0;
         err_q          <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmo_q         <= tmo_d;
         err_q         <= err_d;
         busy_q        <= (state_d != S_IDLE);
         alu_clk_en_q  <= (state_d == S_ALU_FUN) || (state_d == S_ALU_WAIT);
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         alu_en_q      <= 1'b0;
         fifo_wr_inc_q <= 1'b0;
         case (state_q)
            S_RFW_ADDR: if (RX_D_VLD) rf_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            S_RFW_DATA: if (RX_D_VLD) begin
               rf_wr_en_q   <= 1'b1;
               rf_wr_data_q <= RX_P_DATA;
            end
            S_RFR_ADDR: if (RX_D_VLD) begin
               rf_rd_en_q <= 1'b1;
               rf_addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
            end
            S_RFR_WAIT: if (RF_RD_DATA_VLD) begin
               tx_buf_q <= RES_W'(RF_RD_DATA);
               cnt_q    <= CNT_W'(1);
            end
            // ALU operands live in RF locations 0 and 1.
            S_ALU_A: if (RX_D_VLD) begin
               rf_wr_en_q   <= 1'b1;
               rf_addr_q    <= '0;
               rf_wr_data_q <= RX_P_DATA;
            end
            S_ALU_B: if (RX_D_VLD) begin
               rf_wr_en_q   <= 1'b1;
               rf_addr_q    <= ADDR_WIDTH'(1);
               rf_wr_data_q <= RX_P_DATA;
            end
            S_ALU_FUN: if (RX_D_VLD) begin
               alu_en_q  <= 1'b1;
               alu_fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
            end
            S_ALU_WAIT: if (ALU_OUT_VLD) begin
               tx_buf_q <= ALU_OUT;
               cnt_q    <= CNT_W'(RES_BYTES);
            end
            S_TX_PUSH: if (!FIFO_FULL) begin
               fifo_wr_inc_q  <= 1'b1;
               fifo_wr_data_q <= tx_buf_q[DATA_WIDTH-1:0];
               tx_buf_q       <= tx_buf_q >> DATA_WIDTH;
               cnt_q          <= cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign RF_ADDR      = rf_addr_q;
   assign RF_WR_DATA   = rf_wr_data_q;
   assign RF_WR_EN     = rf_wr_en_q;
   assign RF_RD_EN     = rf_rd_en_q;
   assign ALU_FUN      = alu_fun_q;
   assign ALU_EN       = alu_en_q;
   assign ALU_CLK_EN   = alu_clk_en_q;
   assign FIFO_WR_DATA = fifo_wr_data_q;
   assign FIFO_WR_INC  = fifo_wr_inc_q;
   assign ERR_FLAG     = err_q;
   assign BUSY         = busy_q;

endmodule
